// File: rtl/tow_pkg.sv
// tow_pkg: shared types and constants for the tug-of-war match scorekeeper.
//   sk_state_e  : scorekeeper FSM states
//   SEG_BLANK   : all segments off (active-low)
//   SEG_TABLE   : active-low {g..a} patterns for decimal digits 0..9
package tow_pkg;

    typedef enum logic [2:0] {
        PLAY       = 3'd0,
        HOLD       = 3'd1,
        RESTART    = 3'd2,
        WAIT_CLR   = 3'd3,
        MATCH_DONE = 3'd4
    } sk_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Packed so that SEG_TABLE[n] is the pattern for digit n (entry 0 is the LSB slice).
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

endpackage

// File: rtl/match_scorekeeper_if.sv
// match_scorekeeper_if: bundle between the round logic / board IO and the scorekeeper.
//   round_over, left_won, new_match   : requests into the scorekeeper
//   round_restart, match_over, match_left, l_score, r_score, hex_l, hex_r : results
//   master modport = driver of the requests, slave modport = the scorekeeper
interface match_scorekeeper_if;

    logic       round_over;
    logic       left_won;
    logic       new_match;
    logic       round_restart;
    logic       match_over;
    logic       match_left;
    logic [3:0] l_score;
    logic [3:0] r_score;
    logic [6:0] hex_l;
    logic [6:0] hex_r;

    modport master (
        output round_over, left_won, new_match,
        input  round_restart, match_over, match_left, l_score, r_score, hex_l, hex_r
    );

    modport slave (
        input  round_over, left_won, new_match,
        output round_restart, match_over, match_left, l_score, r_score, hex_l, hex_r
    );

endinterface

// File: rtl/match_scorekeeper_seg7_digit.sv
// seg7_digit: combinational decode of a 4-bit value to active-low {g..a} segments.
//   digit_i : value to show (0..9 decoded, 10..15 blanked)
//   seg_o   : active-low segment pattern
module seg7_digit
    import tow_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    // Table lookup for decimal digits, blank for anything out of range.
    always_comb begin
        seg_o = SEG_BLANK;
        if (digit_i <= 4'd9) begin
            seg_o = SEG_TABLE[digit_i];
        end else begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/match_scorekeeper.sv
// match_scorekeeper: counts round wins per player, issues a delayed one-cycle
// round_restart after each non-final round, and latches the match winner.
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : slave side of match_scorekeeper_if (requests in, score/status out)
module match_scorekeeper
    import tow_pkg::*;
#(
    parameter int unsigned WINS_TO_MATCH = 5,
    parameter int unsigned RESTART_DELAY = 50_000_000
) (
    input  logic          clk,
    input  logic          reset,
    match_scorekeeper_if.slave bus
);

    localparam int unsigned CW = $clog2(RESTART_DELAY + 1);
    localparam logic [3:0]  WINS_C = 4'(WINS_TO_MATCH);

    sk_state_e     state_q, state_d;
    logic [3:0]    l_q, l_d, r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          restart_q, restart_d;
    logic          mo_q, mo_d;
    logic          ml_q, ml_d;

    logic [3:0]    win_next_s;

    // Score the round winner would have after this round is accepted.
    assign win_next_s = (bus.left_won ? l_q : r_q) + 4'd1;

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= PLAY;
            l_q       <= 4'd0;
            r_q       <= 4'd0;
            cnt_q     <= {CW{1'b0}};
            restart_q <= 1'b0;
            mo_q      <= 1'b0;
            ml_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            l_q       <= l_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            restart_q <= restart_d;
            mo_q      <= mo_d;
            ml_q      <= ml_d;
        end
    end

    // Next-state logic; round_restart is registered, so it is raised on the
    // transition into RESTART and is therefore high exactly while in RESTART.
    always_comb begin
        state_d   = state_q;
        l_d       = l_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        restart_d = 1'b0;
        mo_d      = mo_q;
        ml_d      = ml_q;

        if (bus.new_match) begin
            // Fresh match wins over anything else happening this cycle.
            l_d       = 4'd0;
            r_d       = 4'd0;
            mo_d      = 1'b0;
            ml_d      = 1'b0;
            state_d   = RESTART;
            restart_d = 1'b1;
        end else begin
            case (state_q)
                PLAY: begin
                    if (bus.round_over) begin
                        if (bus.left_won) begin
                            l_d = win_next_s;
                        end else begin
                            r_d = win_next_s;
                        end
                        if (win_next_s >= WINS_C) begin
                            state_d = MATCH_DONE;
                            mo_d    = 1'b1;
                            ml_d    = bus.left_won;
                        end else begin
                            state_d = HOLD;
                            cnt_d   = CW'(RESTART_DELAY - 1);
                        end
                    end else begin
                        state_d = PLAY;
                    end
                end
                HOLD: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d   = RESTART;
                        restart_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                RESTART: begin
                    state_d = WAIT_CLR;
                end
                WAIT_CLR: begin
                    // Wait for the round logic to drop its level before counting again.
                    if (!bus.round_over) begin
                        state_d = PLAY;
                    end else begin
                        state_d = WAIT_CLR;
                    end
                end
                MATCH_DONE: begin
                    state_d = MATCH_DONE;
                    mo_d    = 1'b1;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    assign bus.round_restart = restart_q;
    assign bus.match_over    = mo_q;
    assign bus.match_left    = ml_q;
    assign bus.l_score       = l_q;
    assign bus.r_score       = r_q;

    seg7_digit u_seg_l (
        .digit_i (l_q),
        .seg_o   (bus.hex_l)
    );

    seg7_digit u_seg_r (
        .digit_i (r_q),
        .seg_o   (bus.hex_r)
    );

endmodule

// File: tb/tb_match_scorekeeper.sv
// Directed bench for match_scorekeeper with WINS_TO_MATCH=3, RESTART_DELAY=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_match_scorekeeper;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   n_pulse;

    match_scorekeeper_if bus ();

    match_scorekeeper #(
        .WINS_TO_MATCH (3),
        .RESTART_DELAY (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset          = 1'b0;
        bus.round_over = 1'b0;
        bus.left_won   = 1'b0;
        bus.new_match  = 1'b0;
        step();
        step();

        // 1: idle after reset
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_restart", 32'(bus.round_restart), 32'd0);
            check("idle_match_over", 32'(bus.match_over), 32'd0);
        end
        check("idle_l", 32'(bus.l_score), 32'd0);
        check("idle_r", 32'(bus.r_score), 32'd0);
        check("idle_hex_l", 32'(bus.hex_l), 32'b1000000);
        check("idle_hex_r", 32'(bus.hex_r), 32'b1000000);
        check("idle_match_left", 32'(bus.match_left), 32'd0);

        // 2: left wins a round, round_over held for 20 cycles
        bus.round_over = 1'b1;
        bus.left_won   = 1'b1;
        step();
        check("t2_l_first", 32'(bus.l_score), 32'd1);
        check("t2_hex_l", 32'(bus.hex_l), 32'b1111001);
        check("t2_restart_k0", 32'(bus.round_restart), 32'd0);
        for (int k = 1; k < 20; k++) begin
            step();
            check("t2_restart_timing", 32'(bus.round_restart), (k == 4) ? 32'd1 : 32'd0);
            check("t2_l_held", 32'(bus.l_score), 32'd1);
        end
        bus.round_over = 1'b0;
        step();
        check("t2_r", 32'(bus.r_score), 32'd0);

        // reset between tests so the match starts at 0/0
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("rst_l", 32'(bus.l_score), 32'd0);

        // 3: three right wins -> match to right
        for (int w = 1; w <= 3; w++) begin
            bus.round_over = 1'b1;
            bus.left_won   = 1'b0;
            step();
            check("t3_r_score", 32'(bus.r_score), 32'(w));
            n_pulse = 0;
            for (int k = 1; k <= 7; k++) begin
                step();
                if (bus.round_restart === 1'b1) n_pulse++;
            end
            check("t3_pulses", 32'(n_pulse), (w < 3) ? 32'd1 : 32'd0);
            bus.round_over = 1'b0;
            step();
        end
        check("t3_hex_r", 32'(bus.hex_r), 32'b0110000);
        check("t3_match_over", 32'(bus.match_over), 32'd1);
        check("t3_match_left", 32'(bus.match_left), 32'd0);
        bus.round_over = 1'b1;
        bus.left_won   = 1'b1;
        step();
        step();
        bus.round_over = 1'b0;
        step();
        check("t3_frozen_l", 32'(bus.l_score), 32'd0);
        check("t3_frozen_r", 32'(bus.r_score), 32'd3);
        check("t3_still_over", 32'(bus.match_over), 32'd1);

        // 4: new_match from MATCH_DONE
        bus.new_match = 1'b1;
        step();
        bus.new_match = 1'b0;
        check("t4_l", 32'(bus.l_score), 32'd0);
        check("t4_r", 32'(bus.r_score), 32'd0);
        check("t4_match_over", 32'(bus.match_over), 32'd0);
        check("t4_restart", 32'(bus.round_restart), 32'd1);
        step();
        check("t4_restart_off", 32'(bus.round_restart), 32'd0);
        step();

        // 5: new_match together with round_over in PLAY
        bus.new_match  = 1'b1;
        bus.round_over = 1'b1;
        bus.left_won   = 1'b1;
        step();
        bus.new_match = 1'b0;
        check("t5_l", 32'(bus.l_score), 32'd0);
        check("t5_r", 32'(bus.r_score), 32'd0);
        check("t5_restart", 32'(bus.round_restart), 32'd1);
        n_pulse = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.round_restart === 1'b1) n_pulse++;
        end
        check("t5_single_pulse", 32'(n_pulse), 32'd0);
        check("t5_l_after", 32'(bus.l_score), 32'd0);
        bus.round_over = 1'b0;
        step();

        // 6: reset in HOLD with l_score = 2
        bus.round_over = 1'b1;
        bus.left_won   = 1'b1;
        step();
        check("t6_l1", 32'(bus.l_score), 32'd1);
        for (int k = 0; k < 5; k++) step();
        bus.round_over = 1'b0;
        step();
        bus.round_over = 1'b1;
        step();
        check("t6_l2", 32'(bus.l_score), 32'd2);
        bus.round_over = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("t6_l_rst", 32'(bus.l_score), 32'd0);
        check("t6_r_rst", 32'(bus.r_score), 32'd0);
        n_pulse = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.round_restart === 1'b1) n_pulse++;
        end
        check("t6_no_restart", 32'(n_pulse), 32'd0);
        check("t6_l_after", 32'(bus.l_score), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
